// File: rtl/nibble_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : nibble_adder_pkg
// Brief  : Shared slice width and FSM encoding for the nibble-serial adder.
// Rev    : 1.0
// ============================================================================
package nibble_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module : ripple_carry_adder
// Brief  : 4-bit ripple-carry adder slice with carry in and carry out.
// Rev    : 1.0
// ============================================================================
module ripple_carry_adder
    import nibble_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c,
    output logic [SLICE_W-1:0] sum,
    output logic               carry
);

    logic [SLICE_W:0] chain;

    assign chain[0] = c;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ chain[i];
        assign chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end

    assign carry = chain[SLICE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module : nibble_serial_adder_ctrl
// Brief  : WIDTH-bit adder built from one 4-bit slice stepped LSB-first,
//          one nibble per clock, with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    ripple_carry_adder u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c     (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_carry;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_carry;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            // Unused encoding falls back to a safe idle.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_nibble_serial_adder_ctrl
// Brief  : Scoreboard bench for the nibble-serial adder (WIDTH=16).
// Rev    : 1.0
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSLICE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_edge = -1;
    int   prev_acc = -1;
    bit   gap_chk  = 1'b0;
    logic prev_ov  = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output-side monitor: latency, issue gap and scoreboard compare.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (in_valid && in_ready) begin
                prev_acc = acc_edge;
                acc_edge = cyc + 1;
                if (gap_chk && prev_acc >= 0)
                    chk("issue_gap", acc_edge - prev_acc, NSLICE + 2);
            end
            if (out_valid && !prev_ov)
                chk("latency", cyc - acc_edge, NSLICE);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                end
            end
        end
        prev_ov = out_valid;
    end

    // Present operands until accepted; caller sits just after a rising edge.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input bit push, input bit keep);
        logic [WIDTH:0] full;
        bit accepted;
        accepted = 1'b0;
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
        end else if (push) begin
            full = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc};
            sb.push_back('{full[WIDTH-1:0], full[WIDTH]});
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
        drain();
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drain();
        do_op(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
        drain();

        // Result held in DONE while the consumer stalls.
        out_ready = 1'b0;
        do_op(16'hABCD, 16'h1111, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_sum", sum, 16'hBCDF);
            chk("hold_cout", cout, 0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            if (i == 1) begin
                a = 16'h0F0F;
                b = 16'h0F0F;
                in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("no_stale_out", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Abort mid-operation at idx=2.
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(posedge clk);
        #1;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drain();

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        do_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        gap_chk = 1'b1;
        do_op(16'hC3C3, 16'h5A5A, 1'b0, 1'b1, 1'b0);
        gap_chk = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
